// File: rtl/hs_tx_serializer.sv
// HS lane transmitter: PPI byte handshake in, LSB-first serial lane out, wrapped in HS-zero/sync/trail.
// Optional HS-trail is built only when HS_TX_TRAIL_EN is defined.
module hs_tx_serializer #(
  parameter int unsigned ZERO_LEN  = 8,
  parameter int unsigned TRAIL_LEN = 16,
  parameter logic [7:0]  SYNC_BYTE = 8'hB8
) (
  input  logic       TxDDRClkHS,
  input  logic       RST,
  input  logic       TxRequestHS,
  input  logic [7:0] TxDataHS,
  output logic       TxReadyHS,
  output logic       TxActiveHS,
  output logic       HS_TX_EN,
  output logic       HS_TX_DATA,
  output logic       TxByteClkHS
);

  localparam int unsigned CNT_MAX = (ZERO_LEN > TRAIL_LEN) ? ZERO_LEN : TRAIL_LEN;
  localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    ZERO  = 3'd1,
    SYNC  = 3'd2,
    DATA  = 3'd3,
    TRAIL = 3'd4
  } txState_e;

  txState_e         state;
  logic [2:0]       bi;
  logic [CNT_W-1:0] cnt;
  logic [7:0]       shreg;
  logic             startPend;
  logic [2:0]       byteCnt;

  // Outputs are updated together with the state, so they always describe the current bit cycle.
  // startPend delays burst start by one cycle after the request is sampled in IDLE.
  always_ff @(posedge TxDDRClkHS) begin
    if (RST) begin
      state       <= IDLE;
      bi          <= '0;
      cnt         <= '0;
      shreg       <= '0;
      startPend   <= 1'b0;
      byteCnt     <= '0;
      TxReadyHS   <= 1'b0;
      TxActiveHS  <= 1'b0;
      HS_TX_EN    <= 1'b0;
      HS_TX_DATA  <= 1'b0;
      TxByteClkHS <= 1'b0;
    end else begin
      byteCnt     <= byteCnt + 3'd1;
      TxByteClkHS <= (byteCnt < 3'd4);
      TxReadyHS   <= 1'b0;

      case (state)
        IDLE: begin
          if (startPend) begin
            state      <= ZERO;
            cnt        <= '0;
            startPend  <= 1'b0;
            HS_TX_EN   <= 1'b1;
            TxActiveHS <= 1'b1;
            HS_TX_DATA <= 1'b0;
          end else begin
            startPend <= TxRequestHS;
          end
        end

        ZERO: begin
          if (cnt == CNT_W'(ZERO_LEN - 1)) begin
            state      <= SYNC;
            bi         <= '0;
            HS_TX_DATA <= SYNC_BYTE[0];
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end

        SYNC, DATA: begin
          if (bi == 3'd7) begin
            if (TxRequestHS) begin
              shreg      <= TxDataHS;
              state      <= DATA;
              bi         <= '0;
              HS_TX_DATA <= TxDataHS[0];
            end else begin
`ifdef HS_TX_TRAIL_EN
              // HS_TX_DATA still holds the last transmitted bit here
              state      <= TRAIL;
              cnt        <= '0;
              HS_TX_DATA <= ~HS_TX_DATA;
`else
              state      <= IDLE;
              HS_TX_EN   <= 1'b0;
              TxActiveHS <= 1'b0;
              HS_TX_DATA <= 1'b0;
`endif
            end
          end else begin
            bi         <= bi + 3'd1;
            HS_TX_DATA <= (state == SYNC) ? SYNC_BYTE[bi + 3'd1] : shreg[bi + 3'd1];
            TxReadyHS  <= (bi == 3'd6);
          end
        end

`ifdef HS_TX_TRAIL_EN
        TRAIL: begin
          if (cnt == CNT_W'(TRAIL_LEN - 1)) begin
            state      <= IDLE;
            HS_TX_EN   <= 1'b0;
            TxActiveHS <= 1'b0;
            HS_TX_DATA <= 1'b0;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
`endif

        default: begin
          state      <= IDLE;
          HS_TX_EN   <= 1'b0;
          TxActiveHS <= 1'b0;
          HS_TX_DATA <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_hs_tx_serializer.sv
// Scoreboard bench for hs_tx_serializer: expected lane bits queued per burst, popped as HS_TX_EN cycles occur.
module tb_hs_tx_serializer;

  localparam int unsigned ZERO_LEN  = 8;
  localparam int unsigned TRAIL_LEN = 16;
  localparam logic [7:0]  SYNC_BYTE = 8'hB8;
`ifdef HS_TX_TRAIL_EN
  localparam bit TRAIL_ON = 1'b1;
`else
  localparam bit TRAIL_ON = 1'b0;
`endif

  logic       clk;
  logic       rst;
  logic       req;
  logic [7:0] txData;
  logic       TxReadyHS, TxActiveHS, HS_TX_EN, HS_TX_DATA, TxByteClkHS;

  hs_tx_serializer #(
    .ZERO_LEN (ZERO_LEN),
    .TRAIL_LEN(TRAIL_LEN),
    .SYNC_BYTE(SYNC_BYTE)
  ) dut (
    .TxDDRClkHS (clk),
    .RST        (rst),
    .TxRequestHS(req),
    .TxDataHS   (txData),
    .TxReadyHS  (TxReadyHS),
    .TxActiveHS (TxActiveHS),
    .HS_TX_EN   (HS_TX_EN),
    .HS_TX_DATA (HS_TX_DATA),
    .TxByteClkHS(TxByteClkHS)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int         nTests = 0;
  int         nFail  = 0;
  logic       expQ[$];
  logic [7:0] txQ[$];
  int         readyCnt = 0;
  int         enCnt    = 0;
  int         accCnt   = 0;
  bit         monOn    = 1'b0;
  logic       prevReady = 1'b0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nTests++;
    assert (obs === exp) else begin
      nFail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Lane monitor: compares every driven bit against the scoreboard
  always @(negedge clk) begin
    if (monOn) begin
      check("active_eq_en", 32'(TxActiveHS), 32'(HS_TX_EN));
      check("ready_single_pulse", 32'(TxReadyHS && prevReady), 32'(0));
      prevReady = TxReadyHS;
      if (TxReadyHS) readyCnt++;
      if (HS_TX_EN) begin
        enCnt++;
        if (expQ.size() == 0) check("extra_bit", 32'(HS_TX_EN), 32'(0));
        else check("lane_bit", 32'(HS_TX_DATA), 32'(expQ.pop_front()));
      end else begin
        check("idle_data_low", 32'(HS_TX_DATA), 32'(0));
      end
    end
  end

  task automatic pushByte(input logic [7:0] b);
    for (int i = 0; i < 8; i++) expQ.push_back(b[i]);
  endtask

  // Queues the expected lane image, drives the burst from txQ, then checks burst-level counts
  task automatic runBurst(input string tag);
    int   nBytes;
    logic lastBit;
    int   expEn;
    bit   started;
    bit   done;
    int   firstC;
    nBytes = txQ.size();
    for (int i = 0; i < int'(ZERO_LEN); i++) expQ.push_back(1'b0);
    pushByte(SYNC_BYTE);
    for (int i = 0; i < nBytes; i++) pushByte(txQ[i]);
    lastBit = (nBytes > 0) ? txQ[nBytes-1][7] : SYNC_BYTE[7];
    expEn = int'(ZERO_LEN) + 8 + 8 * nBytes;
    if (TRAIL_ON) begin
      for (int i = 0; i < int'(TRAIL_LEN); i++) expQ.push_back(~lastBit);
      expEn += int'(TRAIL_LEN);
    end
    readyCnt = 0;
    enCnt    = 0;
    accCnt   = 0;
    started  = 1'b0;
    done     = 1'b0;
    firstC   = -1;

    @(negedge clk);
    req    = 1'b1;
    txData = (nBytes > 0) ? txQ[0] : 8'h00;
    if (nBytes == 0) begin
      @(posedge clk);
      #1 req = 1'b0;
    end
    for (int c = 0; c < 400 && !done; c++) begin
      @(negedge clk);
      if (HS_TX_EN) begin
        if (!started) firstC = c;
        started = 1'b1;
      end else if (started) begin
        done = 1'b1;
      end
      if (req && TxReadyHS) begin
        accCnt++;
        void'(txQ.pop_front());
        @(posedge clk);
        #1;
        if (txQ.size() == 0) req = 1'b0;
        else txData = txQ[0];
      end
    end
    check({tag, "_completed"}, 32'(done), 32'(1));
    check({tag, "_start_latency"}, 32'(firstC), 32'(1));
    check({tag, "_bits_left"}, 32'(expQ.size()), 32'(0));
    check({tag, "_ready_pulses"}, 32'(readyCnt), 32'(nBytes + 1));
    check({tag, "_accepted"}, 32'(accCnt), 32'(nBytes));
    check({tag, "_en_cycles"}, 32'(enCnt), 32'(expEn));
    expQ.delete();
    req = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int  myCnt;
    bit  hit;

    // Reset held with request asserted
    rst    = 1'b1;
    req    = 1'b1;
    txData = 8'h00;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_ready", 32'(TxReadyHS), 32'(0));
    check("rst_active", 32'(TxActiveHS), 32'(0));
    check("rst_en", 32'(HS_TX_EN), 32'(0));
    check("rst_data", 32'(HS_TX_DATA), 32'(0));
    check("rst_byteclk", 32'(TxByteClkHS), 32'(0));
    monOn = 1'b1;
    rst   = 1'b0;
    req   = 1'b0;

    // Free-running byte clock: high for counter values 0..3, one register stage behind
    for (int k = 1; k <= 16; k++) begin
      @(posedge clk);
      @(negedge clk);
      check("byteclk", 32'(TxByteClkHS), 32'(((k - 1) % 8) < 4));
    end

    txQ = '{8'h5A};
    runBurst("single_5a");
    repeat (2) @(negedge clk);

    txQ = '{8'hCE, 8'h0F, 8'hF0};
    runBurst("multi");
    repeat (2) @(negedge clk);

    txQ.delete();
    runBurst("empty");
    repeat (2) @(negedge clk);

    // Reset during bit 3 of the second data byte
    expQ.delete();
    for (int i = 0; i < int'(ZERO_LEN); i++) expQ.push_back(1'b0);
    pushByte(SYNC_BYTE);
    pushByte(8'hCE);
    pushByte(8'h0F);
    txQ    = '{8'hCE, 8'h0F, 8'hF0};
    accCnt = 0;
    myCnt  = 0;
    hit    = 1'b0;
    @(negedge clk);
    req    = 1'b1;
    txData = txQ[0];
    for (int c = 0; c < 300 && !hit; c++) begin
      @(negedge clk);
      if (HS_TX_EN) myCnt++;
      if (myCnt == int'(ZERO_LEN) + 8 + 8 + 4) begin
        rst = 1'b1;
        hit = 1'b1;
      end else if (req && TxReadyHS) begin
        accCnt++;
        void'(txQ.pop_front());
        @(posedge clk);
        #1;
        if (txQ.size() == 0) req = 1'b0;
        else txData = txQ[0];
      end
    end
    check("rstmid_reached", 32'(hit), 32'(1));
    @(posedge clk);
    @(negedge clk);
    check("rstmid_en", 32'(HS_TX_EN), 32'(0));
    check("rstmid_active", 32'(TxActiveHS), 32'(0));
    check("rstmid_ready", 32'(TxReadyHS), 32'(0));
    check("rstmid_accepted", 32'(accCnt), 32'(2));
    rst = 1'b0;
    req = 1'b0;
    expQ.delete();
    txQ.delete();
    enCnt = 0;
    repeat (10) @(negedge clk);
    check("rstmid_stays_idle", 32'(enCnt), 32'(0));

    txQ = '{8'hFF};
    runBurst("single_ff");
    repeat (2) @(negedge clk);

    txQ = '{8'h01, 8'h80};
    runBurst("two_bytes");
    repeat (3) @(negedge clk);

    monOn = 1'b0;
    $display("[TB] %0d tests run, %0d failed", nTests, nFail);
    $finish;
  end

endmodule
